// File: rtl/rgbled_rx_decoder.sv
// rgbled_rx_decoder
// Decodes a WS2812-style single-wire RGB LED bitstream back into per-LED
// colour words (G, R, B order, MSB first) with the word's position in the
// current frame. It also flags frame-end gaps and malformed pulses.
//
// Ports:
//   clk_i        - system clock
//   rst_i        - asynchronous active-high reset
//   din_i        - serial LED data, asynchronous to clk_i
//   led_valid_o  - one-cycle pulse when a 24-bit word completes
//   led_r/g/b_o  - decoded colour, held until the next led_valid_o
//   led_idx_o    - index of the word in the current frame (saturates at 255)
//   frame_done_o - one-cycle pulse at a clean frame end
//   err_o        - one-cycle pulse on glitch, stuck-high or partial word
//   busy_o       - high while a pulse train is being decoded (HIGH/LOW)
module rgbled_rx_decoder #(
  parameter int unsigned BitThreshCycles = 18,
  parameter int unsigned MinHighCycles   = 4,
  parameter int unsigned MaxHighCycles   = 36,
  parameter int unsigned ResetCycles     = 1500,
  parameter logic        InvertIn        = 1'b0,
  parameter int unsigned CntWidth        = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       din_i,
  output logic       led_valid_o,
  output logic [7:0] led_r_o,
  output logic [7:0] led_g_o,
  output logic [7:0] led_b_o,
  output logic [7:0] led_idx_o,
  output logic       frame_done_o,
  output logic       err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [CntWidth-1:0] BitThr = CntWidth'(BitThreshCycles);
  localparam logic [CntWidth-1:0] MinHi  = CntWidth'(MinHighCycles);
  localparam logic [CntWidth-1:0] MaxHi  = CntWidth'(MaxHighCycles);
  localparam logic [CntWidth-1:0] RstLo  = CntWidth'(ResetCycles);

  logic                r_sync1, r_sync2, r_din_d;
  logic                w_din_s, w_rise, w_fall;
  logic [CntWidth-1:0] r_cnt;
  state_t              r_state;
  logic [23:0]         r_shift;
  logic [4:0]          r_bitcnt;
  logic                r_idx_inc;
  logic                w_bit;
  logic [23:0]         w_shift_nxt;

  // Input synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_din_d <= 1'b0;
    end else begin
      r_sync1 <= din_i ^ InvertIn;
      r_sync2 <= r_sync1;
      r_din_d <= r_sync2;
    end
  end

  assign w_din_s = r_sync2;
  assign w_rise  = r_sync2 & ~r_din_d;
  assign w_fall  = ~r_sync2 & r_din_d;

  // Cycles since the last edge; at a falling edge r_cnt equals the number
  // of cycles the line was high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 r_cnt <= '0;
    else if (w_rise || w_fall) r_cnt <= CntOne;
    else if (r_cnt != CntMax)  r_cnt <= r_cnt + CntOne;
  end

  assign w_bit       = (r_cnt >= BitThr);
  assign w_shift_nxt = {r_shift[22:0], w_bit};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_SYNC;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_idx_inc    <= 1'b0;
      led_valid_o  <= 1'b0;
      led_r_o      <= '0;
      led_g_o      <= '0;
      led_b_o      <= '0;
      led_idx_o    <= '0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      led_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      r_idx_inc    <= 1'b0;
      // Index advances the cycle after the word is presented.
      if (r_idx_inc && led_idx_o != 8'hFF) led_idx_o <= led_idx_o + 8'd1;

      case (r_state)
        ST_SYNC: begin
          // A falling edge reloads the counter, so the old count is stale.
          if (!w_din_s && !w_fall && r_cnt >= RstLo) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_rise) r_state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (w_fall) begin
            if (r_cnt < MinHi) begin
              err_o     <= 1'b1;
              r_bitcnt  <= '0;
              led_idx_o <= '0;
              r_state   <= ST_SYNC;
            end else begin
              r_shift <= w_shift_nxt;
              r_state <= ST_LOW;
              if (r_bitcnt == 5'd23) begin
                led_g_o     <= w_shift_nxt[23:16];
                led_r_o     <= w_shift_nxt[15:8];
                led_b_o     <= w_shift_nxt[7:0];
                led_valid_o <= 1'b1;
                r_idx_inc   <= 1'b1;
                r_bitcnt    <= '0;
              end else begin
                r_bitcnt <= r_bitcnt + 5'd1;
              end
            end
          end else if (r_cnt >= MaxHi) begin
            err_o     <= 1'b1;
            r_bitcnt  <= '0;
            led_idx_o <= '0;
            r_state   <= ST_SYNC;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_state <= ST_HIGH;
          end else if (r_cnt >= RstLo) begin
            if (r_bitcnt == 5'd0) frame_done_o <= 1'b1;
            else                  err_o        <= 1'b1;
            r_bitcnt  <= '0;
            led_idx_o <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign busy_o = (r_state == ST_HIGH) || (r_state == ST_LOW);

endmodule

// File: tb/tb_rgbled_rx_decoder.sv
// Testbench for rgbled_rx_decoder: drives WS2812-style pulse trains and
// compares decoded words and frame/error pulses against a bit-level model
// built from the pulse widths that were sent.
module tb_rgbled_rx_decoder;
  localparam int BIT_T = 18;
  localparam int RST_C = 1500;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       din_i = 1'b0;
  logic       led_valid_o;
  logic [7:0] led_r_o, led_g_o, led_b_o, led_idx_o;
  logic       frame_done_o, err_o, busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0, fd_cnt = 0, err_cnt = 0, err_cyc = -1;
  logic [31:0] q_words[$];   // {idx, g, r, b} as observed
  logic [31:0] exp_words[$]; // {idx, g, r, b} from the model
  bit          sent_bits[$];

  rgbled_rx_decoder dut (
    .clk_i(clk_i), .rst_i(rst_i), .din_i(din_i),
    .led_valid_o(led_valid_o), .led_r_o(led_r_o), .led_g_o(led_g_o),
    .led_b_o(led_b_o), .led_idx_o(led_idx_o), .frame_done_o(frame_done_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    cyc++;
    if (led_valid_o) q_words.push_back({led_idx_o, led_g_o, led_r_o, led_b_o});
    if (frame_done_o) fd_cnt++;
    if (err_o) begin err_cnt++; err_cyc = cyc; end
  end

  task automatic tick(); @(posedge clk_i); #1; endtask

  task automatic gap(input int n); din_i = 1'b0; repeat (n) tick(); endtask

  task automatic clear_mon();
    q_words.delete(); sent_bits.delete(); fd_cnt = 0; err_cnt = 0; err_cyc = -1;
  endtask

  // One pulse; the decoded value the model expects follows the threshold rule.
  task automatic send_pulse(input int h, input int l);
    din_i = 1'b1; repeat (h) tick();
    din_i = 1'b0; repeat (l) tick();
    sent_bits.push_back(h >= BIT_T);
  endtask

  // Sends the top nb bits of grb. mode 0: nominal widths, 1: random widths,
  // 2: threshold/minimum boundary widths.
  task automatic send_bits(input logic [23:0] grb, input int nb, input int mode);
    int h, l;
    for (int i = 23; i > 23 - nb; i--) begin
      case (mode)
        0:       begin h = grb[i] ? 24 : 12; l = grb[i] ? 14 : 26; end
        1:       begin h = grb[i] ? $urandom_range(35, 18) : $urandom_range(17, 4);
                       l = $urandom_range(30, 6); end
        default: begin h = grb[i] ? ((i % 2) ? 18 : 35) : ((i % 2) ? 17 : 4); l = 20; end
      endcase
      send_pulse(h, l);
    end
  endtask

  // Groups received bits into 24-bit words, G first, numbering from 0.
  task automatic model_words();
    logic [23:0] val;
    int n, idx;
    val = '0; n = 0; idx = 0;
    exp_words.delete();
    foreach (sent_bits[k]) begin
      val = {val[22:0], sent_bits[k]};
      n++;
      if (n == 24) begin
        exp_words.push_back({8'(idx), val});
        idx++; n = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; din_i = 1'b0;
    repeat (3) tick();
    checks++; if ({led_valid_o, led_r_o, led_g_o, led_b_o, led_idx_o, frame_done_o, err_o, busy_o} !== 36'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {led_valid_o, led_r_o, led_g_o, led_b_o, led_idx_o, frame_done_o, err_o, busy_o}); end
    rst_i = 1'b0;
    clear_mon();
    gap(RST_C + 10);
    checks++; if (fd_cnt + err_cnt + q_words.size() != 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL sync_quiet got fd=%0d err=%0d words=%0d busy=%b want none", fd_cnt, err_cnt, q_words.size(), busy_o); end
  endtask

  task automatic test_single();
    clear_mon();
    send_bits(24'h12A5FF, 24, 0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy_o); end
    gap(RST_C + 20);
    model_words();
    checks++; if (q_words.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", q_words.size()); end
    else begin
      checks++; if (q_words[0] !== 32'h0012A5FF) begin errors++; $display("FAIL single_word got %h want 0012A5FF", q_words[0]); end
      checks++; if (q_words[0] !== exp_words[0]) begin errors++; $display("FAIL single_model got %h want %h", q_words[0], exp_words[0]); end
    end
    checks++; if (fd_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL single_frame got fd=%0d err=%0d want fd=1 err=0", fd_cnt, err_cnt); end
    checks++; if ({led_r_o, led_g_o, led_b_o, busy_o} !== {24'hA512FF, 1'b0}) begin
      errors++; $display("FAIL single_hold got r=%h g=%h b=%h busy=%b want A5 12 FF 0", led_r_o, led_g_o, led_b_o, busy_o); end
  endtask

  task automatic test_multi();
    logic [23:0] w[3];
    logic [23:0] nx;
    w[0] = 24'h000000; w[1] = 24'hFFFFFF; w[2] = 24'h0F0F0F;
    clear_mon();
    for (int i = 0; i < 3; i++) send_bits(w[i], 24, 0);
    gap(RST_C + 20);
    checks++; if (q_words.size() != 3) begin errors++; $display("FAIL multi_count got %0d want 3", q_words.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (q_words[i] !== {8'(i), w[i]}) begin errors++; $display("FAIL multi_word%0d got %h want %h", i, q_words[i], {8'(i), w[i]}); end
    end
    checks++; if (fd_cnt != 1 || err_cnt != 0 || led_idx_o !== 8'd0) begin
      errors++; $display("FAIL multi_frame got fd=%0d err=%0d idx=%0d want 1 0 0", fd_cnt, err_cnt, led_idx_o); end
    clear_mon();
    nx = 24'($urandom);
    send_bits(nx, 24, 1);
    gap(RST_C + 20);
    checks++; if (q_words.size() != 1 || q_words[0] !== {8'd0, nx}) begin
      errors++; $display("FAIL multi_next got n=%0d w=%h want 1 %h", q_words.size(), (q_words.size() > 0) ? q_words[0] : 32'h0, {8'd0, nx}); end
  endtask

  task automatic test_threshold();
    logic [23:0] w;
    clear_mon();
    w = 24'($urandom) | 24'h800001;   // force some ones and zeros either way
    w[12] = 1'b0; w[13] = 1'b0;
    send_bits(w, 24, 2);
    gap(RST_C + 20);
    model_words();
    checks++; if (q_words.size() != 1 || q_words[0] !== {8'd0, w} || exp_words[0] !== {8'd0, w}) begin
      errors++; $display("FAIL threshold_word got n=%0d w=%h want %h", q_words.size(), (q_words.size() > 0) ? q_words[0] : 32'h0, {8'd0, w}); end
    checks++; if (fd_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL threshold_frame got fd=%0d err=%0d want 1 0", fd_cnt, err_cnt); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      clear_mon();
      for (int k = 0; k < int'($urandom_range(3, 1)); k++) send_bits(24'($urandom), 24, 1);
      gap(RST_C + 20);
      model_words();
      checks++; if (q_words.size() != exp_words.size()) begin
        errors++; $display("FAIL random_count f%0d got %0d want %0d", f, q_words.size(), exp_words.size()); end
      else foreach (exp_words[k]) begin
        checks++; if (q_words[k] !== exp_words[k]) begin errors++; $display("FAIL random_word f%0d.%0d got %h want %h", f, k, q_words[k], exp_words[k]); end
      end
      checks++; if (fd_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL random_frame f%0d got fd=%0d err=%0d want 1 0", f, fd_cnt, err_cnt); end
    end
  endtask

  task automatic test_glitch();
    logic [23:0] w;
    clear_mon();
    send_bits(24'($urandom), 5, 1);
    din_i = 1'b1; repeat (3) tick(); din_i = 1'b0;
    gap(RST_C + 20);
    checks++; if (err_cnt != 1 || fd_cnt != 0 || q_words.size() != 0) begin
      errors++; $display("FAIL glitch_err got err=%0d fd=%0d words=%0d want 1 0 0", err_cnt, fd_cnt, q_words.size()); end
    clear_mon();
    w = 24'($urandom);
    send_bits(w, 24, 1);
    gap(RST_C + 20);
    checks++; if (q_words.size() != 1 || q_words[0] !== {8'd0, w} || fd_cnt != 1 || err_cnt != 0) begin
      errors++; $display("FAIL glitch_resume got n=%0d fd=%0d err=%0d want word %h fd=1 err=0", q_words.size(), fd_cnt, err_cnt, {8'd0, w}); end
  endtask

  task automatic test_stuck();
    int t0;
    clear_mon();
    t0 = cyc;
    din_i = 1'b1; repeat (40) tick();
    din_i = 1'b0;
    gap(RST_C + 20);
    // 36 counted cycles plus synchroniser/edge latency and registered output.
    checks++; if (err_cnt != 1 || err_cyc - t0 < 37 || err_cyc - t0 > 40) begin
      errors++; $display("FAIL stuck_err got err=%0d at +%0d want 1 at +37..40", err_cnt, err_cyc - t0); end
    checks++; if (fd_cnt != 0 || q_words.size() != 0) begin
      errors++; $display("FAIL stuck_quiet got fd=%0d words=%0d want 0 0", fd_cnt, q_words.size()); end
  endtask

  task automatic test_partial();
    clear_mon();
    send_bits(24'($urandom), 10, 1);
    gap(RST_C + 20);
    checks++; if (err_cnt != 1 || fd_cnt != 0 || q_words.size() != 0 || led_idx_o !== 8'd0) begin
      errors++; $display("FAIL partial got err=%0d fd=%0d words=%0d idx=%0d want 1 0 0 0", err_cnt, fd_cnt, q_words.size(), led_idx_o); end
  endtask

  task automatic test_mid_reset();
    logic [23:0] w;
    clear_mon();
    send_bits(24'($urandom) | 24'h010101, 24, 1);
    send_bits(24'($urandom), 12, 1);
    checks++; if (led_idx_o !== 8'd1) begin errors++; $display("FAIL midrst_idx got %0d want 1", led_idx_o); end
    rst_i = 1'b1; tick();
    checks++; if ({led_valid_o, led_r_o, led_g_o, led_b_o, led_idx_o, frame_done_o, err_o, busy_o} !== 36'd0) begin
      errors++; $display("FAIL midrst_outputs got %h want 0", {led_valid_o, led_r_o, led_g_o, led_b_o, led_idx_o, frame_done_o, err_o, busy_o}); end
    rst_i = 1'b0;
    gap(RST_C + 20);
    clear_mon();
    w = 24'($urandom);
    send_bits(w, 24, 0);
    gap(RST_C + 20);
    checks++; if (q_words.size() != 1 || q_words[0] !== {8'd0, w} || fd_cnt != 1 || err_cnt != 0) begin
      errors++; $display("FAIL midrst_word got n=%0d fd=%0d err=%0d want word %h fd=1 err=0", q_words.size(), fd_cnt, err_cnt, {8'd0, w}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_threshold();
    test_random();
    test_glitch();
    test_stuck();
    test_partial();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
